// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with two combinational read ports, one writeback port
// and an issue scoreboard that tracks registers with a pending write.
module regfile_sb #(
    parameter  int unsigned XLEN    = 64,
    parameter  int unsigned NREG    = 32,
    parameter  int unsigned ZERO_R0 = 1,
    parameter  int unsigned BYPASS  = 1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_stall,
    output logic [NREG-1:0] busy_vec
);

    localparam logic [AW:0] NREG_A = (AW+1)'(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic            wr_ok;
    logic            iss_ok;
    logic            iss_fire;

    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    logic [1:0]      rd_busy;

    // An address names real storage: in range, and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_A) && !((ZERO_R0 != 0) && (a == '0));
    endfunction

    assign wr_ok     = wr_en && addr_ok(wr_addr);
    assign iss_ok    = iss_en && addr_ok(iss_rd);
    assign iss_stall = iss_ok && busy_q[iss_rd] && !(wr_en && (wr_addr == iss_rd));
    assign iss_fire  = iss_ok && !iss_stall;

    // Writeback clears the pending bit; a same-cycle issue then re-marks it (new producer wins).
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (iss_fire) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    // Read ports: zero for non-storage addresses, forwarded write data when bypassing.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            if (addr_ok(rd_addr[p])) begin
                if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr[p])) begin
                    rd_data[p] = wr_data;
                end else begin
                    rd_data[p] = regs_q[rd_addr[p]];
                    rd_busy[p] = busy_q[rd_addr[p]];
                end
            end
        end
    end

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];
    assign rs1_busy = rd_busy[0];
    assign rs2_busy = rd_busy[1];
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a default instance (zero r0, bypass) driven from a vector
// table, plus a non-bypass, non-power-of-two instance exercised by hand sequences.
module tb_regfile_sb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
    logic [63:0] wr_data;
    logic        wr_en, iss_en;

    logic [63:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
    logic        a_rs1_busy, a_rs2_busy, a_iss_stall;
    logic        b_rs1_busy, b_rs2_busy, b_iss_stall;
    logic [31:0] a_busy_vec;
    logic [23:0] b_busy_vec;

    regfile_sb #(.XLEN(64), .NREG(32), .ZERO_R0(1), .BYPASS(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
        .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_stall(a_iss_stall),
        .busy_vec(a_busy_vec)
    );

    regfile_sb #(.XLEN(64), .NREG(24), .ZERO_R0(0), .BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_stall(b_iss_stall),
        .busy_vec(b_busy_vec)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        ie;
        logic [4:0]  ir;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [63:0] e1;
        logic [63:0] e2;
        logic        eb1;
        logic        eb2;
        logic        est;
        logic [31:0] ebv;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mkv(input logic rst, we, input logic [4:0] wa, input logic [63:0] wd,
                                 input logic ie, input logic [4:0] ir, a1, a2,
                                 input logic [63:0] e1, e2, input logic eb1, eb2, est,
                                 input logic [31:0] ebv);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ir = ir;
        v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2;
        v.eb1 = eb1; v.eb2 = eb2; v.est = est; v.ebv = ebv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs just after the falling edge; outputs are sampled 2 time units later.
    task automatic cyc(input logic r, we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic ie, input logic [4:0] ir, a1, a2);
        @(negedge clk);
        rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_rd = ir; rs1_addr = a1; rs2_addr = a2;
        #2;
        n_vec++;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;

        //          rst we wa  wd                      ie ir  a1  a2 | e1                      e2                      b1 b2 st busy_vec
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  0, 0,  0,  5,  64'h0,                  64'h0,                  0, 0, 0, 32'h0));
        vecs.push_back(mkv(1, 1, 5,  64'hDEAD_BEEF,          0, 0,  5,  3,  64'hDEAD_BEEF,          64'h0,                  0, 0, 0, 32'h0));
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  0, 0,  5,  5,  64'hDEAD_BEEF,          64'hDEAD_BEEF,          0, 0, 0, 32'h0));
        vecs.push_back(mkv(1, 1, 0,  64'h1234,               0, 0,  0,  0,  64'h0,                  64'h0,                  0, 0, 0, 32'h0));
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  0, 0,  0,  0,  64'h0,                  64'h0,                  0, 0, 0, 32'h0));
        vecs.push_back(mkv(1, 1, 7,  64'hAA,                 0, 0,  5,  7,  64'hDEAD_BEEF,          64'hAA,                 0, 0, 0, 32'h0));
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  1, 3,  3,  7,  64'h0,                  64'hAA,                 0, 0, 0, 32'h0));
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  1, 3,  3,  7,  64'h0,                  64'hAA,                 1, 0, 1, 32'h8));
        vecs.push_back(mkv(1, 1, 3,  64'h33,                 1, 3,  3,  7,  64'h33,                 64'hAA,                 0, 0, 0, 32'h8));
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  0, 0,  3,  3,  64'h33,                 64'h33,                 1, 1, 0, 32'h8));
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  1, 9,  9,  3,  64'h0,                  64'h33,                 0, 1, 0, 32'h8));
        vecs.push_back(mkv(1, 1, 9,  64'h55,                 0, 0,  9,  3,  64'h55,                 64'h33,                 0, 1, 0, 32'h208));
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  0, 0,  9,  9,  64'h55,                 64'h55,                 0, 0, 0, 32'h8));
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  1, 0,  0,  9,  64'h0,                  64'h55,                 0, 0, 0, 32'h8));
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  0, 0,  0,  3,  64'h0,                  64'h33,                 0, 1, 0, 32'h8));
        vecs.push_back(mkv(1, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 31, 3, 31, 64'h33,                 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 32'h8));
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  0, 0,  3,  31, 64'h33,                 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 32'h8000_0008));
        vecs.push_back(mkv(0, 1, 5,  64'h77,                 1, 4,  31, 3,  64'hFFFF_FFFF_FFFF_FFFF, 64'h33,                 1, 1, 0, 32'h8000_0008));
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  0, 0,  5,  4,  64'h0,                  64'h0,                  0, 0, 0, 32'h0));
        vecs.push_back(mkv(1, 0, 0,  64'h0,                  0, 0,  31, 3,  64'h0,                  64'h0,                  0, 0, 0, 32'h0));

        cyc(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ie, vecs[i].ir,
                vecs[i].a1, vecs[i].a2);
            chk($sformatf("v%0d.rs1_data", i), a_rs1_data, vecs[i].e1);
            chk($sformatf("v%0d.rs2_data", i), a_rs2_data, vecs[i].e2);
            chk($sformatf("v%0d.rs1_busy", i), 64'(a_rs1_busy), 64'(vecs[i].eb1));
            chk($sformatf("v%0d.rs2_busy", i), 64'(a_rs2_busy), 64'(vecs[i].eb2));
            chk($sformatf("v%0d.iss_stall", i), 64'(a_iss_stall), 64'(vecs[i].est));
            chk($sformatf("v%0d.busy_vec", i), 64'(a_busy_vec), 64'(vecs[i].ebv));
        end

        // Fill every register with a pending producer, then reset alongside a write and an issue.
        cyc(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 1; i < 32; i++) begin
            cyc(1'b1, 1'b1, 5'(i), 64'(i) * 64'h101, 1'b1, 5'(i), 5'd0, 5'd0);
        end
        cyc(1'b0, 1'b1, 5'd5, 64'hBAD, 1'b1, 5'd6, 5'd1, 5'd31);
        chk("fill.busy_vec", 64'(a_busy_vec), 64'hFFFF_FFFE);
        chk("fill.rs1_data", a_rs1_data, 64'h101);
        chk("fill.rs2_data", a_rs2_data, 64'h1F1F);
        chk("fill.b_busy_vec", 64'(b_busy_vec), 64'hFF_FFFE);
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'(i), 5'(i));
            chk($sformatf("clr%0d.rs1_data", i), a_rs1_data, 64'h0);
            chk($sformatf("clr%0d.rs2_data", i), a_rs2_data, 64'h0);
            chk($sformatf("clr%0d.rs1_busy", i), 64'(a_rs1_busy), 64'h0);
            chk($sformatf("clr%0d.b_rs1_data", i), b_rs1_data, 64'h0);
        end
        chk("clr.busy_vec", 64'(a_busy_vec), 64'h0);
        chk("clr.b_busy_vec", 64'(b_busy_vec), 64'h0);

        // Non-bypass instance: old value during the write cycle, new value after.
        cyc(1'b1, 1'b1, 5'd7, 64'h11, 1'b0, 5'd0, 5'd0, 5'd0);
        cyc(1'b1, 1'b1, 5'd7, 64'hAA, 1'b0, 5'd0, 5'd0, 5'd7);
        chk("b_nobyp.old", b_rs2_data, 64'h11);
        chk("b_nobyp.busy", 64'(b_rs2_busy), 64'h0);
        chk("a_byp.new", a_rs2_data, 64'hAA);
        cyc(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd7);
        chk("b_nobyp.new", b_rs2_data, 64'hAA);

        // Addresses beyond NREG=24: writes dropped, reads zero, issue ignored.
        cyc(1'b1, 1'b1, 5'd30, 64'h99, 1'b1, 5'd30, 5'd30, 5'd30);
        chk("b_oor.rs1_data_same", b_rs1_data, 64'h0);
        chk("b_oor.stall_same", 64'(b_iss_stall), 64'h0);
        cyc(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd30, 5'd30, 5'd30);
        chk("b_oor.rs1_data", b_rs1_data, 64'h0);
        chk("b_oor.rs1_busy", 64'(b_rs1_busy), 64'h0);
        chk("b_oor.stall", 64'(b_iss_stall), 64'h0);
        chk("b_oor.busy_vec", 64'(b_busy_vec), 64'h0);
        chk("a_30.rs1_data", a_rs1_data, 64'h99);

        // r0 is ordinary storage when not hardwired.
        cyc(1'b1, 1'b1, 5'd0, 64'h1234, 1'b1, 5'd0, 5'd0, 5'd0);
        chk("b_r0.old", b_rs1_data, 64'h0);
        chk("a_r0.byp", a_rs1_data, 64'h0);
        cyc(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 5'd0, 5'd0);
        chk("b_r0.data", b_rs1_data, 64'h1234);
        chk("b_r0.busy", 64'(b_rs1_busy), 64'h1);
        chk("b_r0.stall", 64'(b_iss_stall), 64'h1);
        chk("b_r0.busy_vec", 64'(b_busy_vec), 64'h1);
        chk("a_r0.data", a_rs1_data, 64'h0);
        chk("a_r0.stall", 64'(a_iss_stall), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
